tl_uh_tex_mem_responder: RTL and testbench

TileLink Uncached-Heavyweight slave on a 32-bit data bus. It services the Get bursts issued by the fragment texture cache (up to 128 bytes, 32 beats), plus PutFullData/PutPartialData from the debug/config path, out of a local single-port BRAM texture store. It sits on the memory side of the texture cache's A/D channels. Only one transaction is outstanding at a time.

---
 rtl/tl_uh_tex_mem_responder.sv | 220 ++++++++++++++++++++++
 tb/tb_tl_uh_tex_mem_responder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_uh_tex_mem_responder.sv
// TileLink UH slave that serves texture-cache Get bursts and debug Puts from a
// local single-port BRAM. One transaction is in flight at a time.
module tl_uh_tex_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned MAX_SIZE    = 7
) (
    input  logic        core_clock_i,
    input  logic        core_reset_ni,
    input  logic [2:0]  tmem_a_opcode,
    input  logic [2:0]  tmem_a_param,
    input  logic [3:0]  tmem_a_size,
    input  logic [31:0] tmem_a_address,
    input  logic [3:0]  tmem_a_mask,
    input  logic [31:0] tmem_a_data,
    input  logic        tmem_a_corrupt,
    input  logic        tmem_a_valid,
    output logic        tmem_a_ready,
    output logic [2:0]  tmem_d_opcode,
    output logic [1:0]  tmem_d_param,
    output logic [3:0]  tmem_d_size,
    output logic        tmem_d_denied,
    output logic [31:0] tmem_d_data,
    output logic        tmem_d_corrupt,
    output logic        tmem_d_valid,
    input  logic        tmem_d_ready
);
    localparam int unsigned AW     = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN   = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  MAX_SZ = 4'(MAX_SIZE);
    localparam logic [2:0]  OP_PUTF = 3'd0;
    localparam logic [2:0]  OP_PUTP = 3'd1;
    localparam logic [2:0]  OP_GET  = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_ACK} state_e;

    state_e         state_q;
    logic           a_ready_q, d_valid_q, d_denied_q, d_corrupt_q;
    logic [2:0]     d_opcode_q;
    logic [3:0]     d_size_q;
    logic [31:0]    d_data_q;
    logic           deny_q, issue_done_q, rd_vld_q, sk_vld_q;
    logic [AW-1:0]  base_idx_q;
    logic [4:0]     beat_q, last_q, d_cnt_q;
    logic [31:0]    sk_data_q;

    logic [31:0]    mem [DEPTH_WORDS];
    logic [31:0]    rdata_q;

    // Sizes past 32 beats saturate the 5-bit beat counter at 32 beats.
    function automatic logic [4:0] last_beat(input logic [3:0] sz);
        if (sz <= 4'd2)      return 5'd0;
        else if (sz >= 4'd7) return 5'd31;
        else                 return 5'((6'd1 << (sz - 4'd2)) - 6'd1);
    endfunction

    logic        a_hs, d_hs, op_ok, aligned, in_range, deny_in, rd_issue;
    logic [32:0] off_w, sz_bytes;
    logic [2:0]  occ;
    logic [31:0] inc_data;
    logic        mem_we, mem_ren;
    logic [AW-1:0] mem_addr;
    logic        unused_param;

    assign unused_param = ^tmem_a_param;
    assign a_hs     = tmem_a_valid & a_ready_q;
    assign d_hs     = d_valid_q & tmem_d_ready;
    assign off_w    = {1'b0, tmem_a_address} - {1'b0, BASE_ADDR};
    assign sz_bytes = 33'h1 << tmem_a_size;
    assign op_ok    = (tmem_a_opcode == OP_PUTF) || (tmem_a_opcode == OP_PUTP) ||
                      (tmem_a_opcode == OP_GET);
    assign aligned  = (tmem_a_address & (sz_bytes[31:0] - 32'd1)) == 32'd0;
    // off_w[32] set means the address fell below BASE_ADDR.
    assign in_range = !off_w[32] && ((off_w + sz_bytes) <= SPAN);
    assign deny_in  = !op_ok || (tmem_a_size > MAX_SZ) || !aligned || !in_range;

    // Entries already committed to the output pair (head, skid, read in flight)
    // after this cycle's pop; a new read is issued only if one slot is still free.
    assign occ      = 3'(d_valid_q) + 3'(sk_vld_q) + 3'(rd_vld_q) - 3'(d_hs);
    assign rd_issue = (state_q == S_RD) && !issue_done_q && (occ < 3'd2);
    assign inc_data = deny_q ? 32'h0 : rdata_q;

    always_comb begin
        mem_we   = 1'b0;
        mem_ren  = 1'b0;
        mem_addr = base_idx_q + AW'(beat_q);
        case (state_q)
            S_IDLE: begin
                mem_addr = off_w[AW+1:2];
                mem_we   = a_hs && (tmem_a_opcode != OP_GET) && !deny_in && !tmem_a_corrupt;
            end
            S_WR:    mem_we  = a_hs && !deny_q && !tmem_a_corrupt;
            S_RD:    mem_ren = rd_issue && !deny_q;
            default: ;
        endcase
    end

    always_ff @(posedge core_clock_i) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (tmem_a_mask[b]) mem[mem_addr][8*b +: 8] <= tmem_a_data[8*b +: 8];
            end
        end
        if (mem_ren) rdata_q <= mem[mem_addr];
    end

    always_ff @(posedge core_clock_i or negedge core_reset_ni) begin
        if (!core_reset_ni) begin
            state_q      <= S_IDLE;
            a_ready_q    <= 1'b0;
            d_valid_q    <= 1'b0;
            d_opcode_q   <= 3'd0;
            d_size_q     <= 4'd0;
            d_denied_q   <= 1'b0;
            d_data_q     <= 32'h0;
            d_corrupt_q  <= 1'b0;
            deny_q       <= 1'b0;
            issue_done_q <= 1'b0;
            rd_vld_q     <= 1'b0;
            sk_vld_q     <= 1'b0;
            sk_data_q    <= 32'h0;
            base_idx_q   <= '0;
            beat_q       <= 5'd0;
            last_q       <= 5'd0;
            d_cnt_q      <= 5'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    a_ready_q <= 1'b1;
                    if (a_hs) begin
                        deny_q     <= deny_in;
                        base_idx_q <= off_w[AW+1:2];
                        last_q     <= last_beat(tmem_a_size);
                        d_size_q   <= tmem_a_size;
                        d_denied_q <= deny_in;
                        d_data_q   <= 32'h0;
                        d_cnt_q    <= 5'd0;
                        if (tmem_a_opcode == OP_GET) begin
                            state_q      <= S_RD;
                            a_ready_q    <= 1'b0;
                            beat_q       <= 5'd0;
                            issue_done_q <= 1'b0;
                            d_opcode_q   <= 3'd1;
                            d_corrupt_q  <= deny_in;
                        end else begin
                            beat_q      <= 5'd1;
                            d_opcode_q  <= 3'd0;
                            d_corrupt_q <= 1'b0;
                            if (last_beat(tmem_a_size) == 5'd0) begin
                                state_q   <= S_ACK;
                                a_ready_q <= 1'b0;
                                d_valid_q <= 1'b1;
                            end else begin
                                state_q <= S_WR;
                            end
                        end
                    end
                end
                S_WR: begin
                    if (a_hs) begin
                        if (beat_q == last_q) begin
                            state_q   <= S_ACK;
                            a_ready_q <= 1'b0;
                            d_valid_q <= 1'b1;
                        end else begin
                            beat_q <= beat_q + 5'd1;
                        end
                    end
                end
                S_RD: begin
                    rd_vld_q <= rd_issue;
                    if (rd_issue) begin
                        if (beat_q == last_q) issue_done_q <= 1'b1;
                        else                  beat_q       <= beat_q + 5'd1;
                    end
                    if (d_hs) d_cnt_q <= d_cnt_q + 5'd1;
                    if (d_hs && (d_cnt_q == last_q)) begin
                        state_q   <= S_IDLE;
                        a_ready_q <= 1'b1;
                        d_valid_q <= 1'b0;
                        sk_vld_q  <= 1'b0;
                        rd_vld_q  <= 1'b0;
                    end else if (!d_valid_q || d_hs) begin
                        if (sk_vld_q) begin
                            d_data_q  <= sk_data_q;
                            d_valid_q <= 1'b1;
                            sk_vld_q  <= rd_vld_q;
                            sk_data_q <= inc_data;
                        end else if (rd_vld_q) begin
                            d_data_q  <= inc_data;
                            d_valid_q <= 1'b1;
                        end else begin
                            d_valid_q <= 1'b0;
                        end
                    end else if (rd_vld_q) begin
                        sk_vld_q  <= 1'b1;
                        sk_data_q <= inc_data;
                    end
                end
                S_ACK: begin
                    if (tmem_d_ready) begin
                        state_q   <= S_IDLE;
                        d_valid_q <= 1'b0;
                        a_ready_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tmem_a_ready   = a_ready_q;
    assign tmem_d_valid   = d_valid_q;
    assign tmem_d_opcode  = d_opcode_q;
    assign tmem_d_param   = 2'b00;
    assign tmem_d_size    = d_size_q;
    assign tmem_d_denied  = d_denied_q;
    assign tmem_d_data    = d_data_q;
    assign tmem_d_corrupt = d_corrupt_q;
endmodule

// File: tb/tb_tl_uh_tex_mem_responder.sv
// Bench for tl_uh_tex_mem_responder: directed Get/Put sequences, a vector table
// and random traffic checked against a word-array memory model.
module tb_tl_uh_tex_mem_responder;
    localparam int          DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          MAXS  = 7;

    logic        clk = 1'b0, rst_n = 1'b1;
    logic [2:0]  a_opcode = '0, a_param = '0;
    logic [3:0]  a_size = '0, a_mask = '0;
    logic [31:0] a_address = '0, a_data = '0;
    logic        a_corrupt = 1'b0, a_valid = 1'b0, d_ready = 1'b0;
    logic        a_ready, d_denied, d_corrupt, d_valid;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [3:0]  d_size;
    logic [31:0] d_data;

    always #5 clk = ~clk;

    tl_uh_tex_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .MAX_SIZE(MAXS)) dut (
        .core_clock_i(clk), .core_reset_ni(rst_n),
        .tmem_a_opcode(a_opcode), .tmem_a_param(a_param), .tmem_a_size(a_size),
        .tmem_a_address(a_address), .tmem_a_mask(a_mask), .tmem_a_data(a_data),
        .tmem_a_corrupt(a_corrupt), .tmem_a_valid(a_valid), .tmem_a_ready(a_ready),
        .tmem_d_opcode(d_opcode), .tmem_d_param(d_param), .tmem_d_size(d_size),
        .tmem_d_denied(d_denied), .tmem_d_data(d_data), .tmem_d_corrupt(d_corrupt),
        .tmem_d_valid(d_valid), .tmem_d_ready(d_ready)
    );

    int          tests = 0, fails = 0;
    logic [31:0] mdl [DEPTH];
    logic [31:0] pdata [32];
    logic [3:0]  pmask [32];
    logic        pcor  [32];
    logic [31:0] last_data;

    typedef struct {
        logic [3:0]  sz;
        logic [31:0] addr;
        bit          den;
        int          n;
        int          mode;
    } gvec_t;
    gvec_t gv [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expired(input string name);
        tests++;
        fails++;
        $display("FAIL %s: no response within cycle budget", name);
    endtask

    function automatic int nb(input logic [3:0] sz);
        return (sz <= 2) ? 1 : (1 << (sz - 2));
    endfunction

    function automatic bit deny_f(input logic [2:0] op, input logic [3:0] sz, input logic [31:0] addr);
        longint a, bytes, lo, hi;
        a = addr; bytes = longint'(1) << sz; lo = BASE; hi = lo + 4 * DEPTH;
        if (op != 3'd0 && op != 3'd1 && op != 3'd4) return 1'b1;
        if (int'(sz) > MAXS) return 1'b1;
        if (a % bytes != 0) return 1'b1;
        if (a < lo || a + bytes > hi) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int widx(input logic [31:0] addr, input int b);
        logic [31:0] w;
        w = (addr - BASE) >> 2;
        return (int'(w & 32'(DEPTH - 1)) + b) % DEPTH;
    endfunction

    task automatic do_put(input logic [2:0] op, input logic [3:0] sz, input logic [31:0] addr, input bit exp_den);
        int n, t;
        n = nb(sz);
        for (int b = 0; b < n; b++) begin
            a_valid = 1'b1; a_opcode = op; a_size = sz; a_address = addr;
            a_mask = pmask[b]; a_data = pdata[b]; a_corrupt = pcor[b]; a_param = 3'($urandom);
            if (b > 0) begin
                a_opcode = 3'($urandom); a_size = 4'($urandom); a_address = $urandom;
            end
            t = 0;
            while (!a_ready && t < 100) begin @(negedge clk); t++; end
            if (t >= 100) begin expired("put_a_ready"); a_valid = 1'b0; return; end
            @(negedge clk);
        end
        a_valid = 1'b0;
        if (!exp_den)
            for (int b = 0; b < n; b++)
                for (int k = 0; k < 4; k++)
                    if (pmask[b][k] && !pcor[b]) mdl[widx(addr, b)][8*k +: 8] = pdata[b][8*k +: 8];
        d_ready = 1'b0;
        t = 0;
        while (!d_valid && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) begin expired("put_ack"); return; end
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            chk("ack_hold", {d_valid, a_ready}, 2'b10);
        end
        chk("ack_fields", {d_opcode, d_param, d_size, d_denied, d_corrupt}, {3'd0, 2'd0, sz, exp_den, 1'b0});
        d_ready = 1'b1;
        @(negedge clk);
        d_ready = 1'b0;
        chk("ack_done", {d_valid, a_ready}, 2'b01);
    endtask

    // mode 0: d_ready high; 1: toggling with a 3-cycle stall; 2: random
    task automatic do_get(input logic [3:0] sz, input logic [31:0] addr, input bit exp_den, input int n, input int mode);
        int t, lat, got, cyc, stall_c;
        logic [40:0] cur, prev, exp;
        bit prev_stall;
        a_valid = 1'b1; a_opcode = 3'd4; a_size = sz; a_address = addr;
        a_mask = 4'($urandom); a_data = $urandom; a_corrupt = 1'b0;
        d_ready = (mode == 0);
        t = 0;
        while (!a_ready && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) begin expired("get_a_ready"); a_valid = 1'b0; return; end
        @(negedge clk);
        a_valid = 1'b0;
        lat = 0;
        while (!d_valid && lat < 20) begin @(negedge clk); lat++; end
        chk("get_latency", lat, 2);
        chk("get_a_ready_low", a_ready, 1'b0);
        got = 0; cyc = 0; prev_stall = 0; prev = '0;
        stall_c = $urandom_range(1, 2 * n);
        while (got < n && cyc < 400) begin
            cur = {d_opcode, d_size, d_denied, d_corrupt, d_data};
            if (prev_stall) chk("stall_stable", {d_valid, cur}, {1'b1, prev});
            if (mode == 0) chk("no_bubble", d_valid, 1'b1);
            case (mode)
                0:       d_ready = 1'b1;
                1:       d_ready = (cyc >= stall_c && cyc < stall_c + 3) ? 1'b0 : 1'(cyc);
                default: d_ready = 1'($urandom_range(0, 1));
            endcase
            if (d_valid && d_ready) begin
                exp = {3'd1, sz, exp_den, exp_den, exp_den ? 32'h0 : mdl[widx(addr, got)]};
                chk($sformatf("get_beat%0d", got), cur, exp);
                last_data = d_data;
                got++;
            end
            prev_stall = d_valid && !d_ready;
            prev = cur;
            @(negedge clk);
            cyc++;
        end
        d_ready = 1'b0;
        if (got < n) expired("get_beats");
        else chk("get_end", {d_valid, a_ready}, 2'b01);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got, t;
        gv[0] = '{4'd7, 32'h0000_0080, 1'b0, 32, 2};
        gv[1] = '{4'd7, 32'h0000_0040, 1'b1, 32, 0};
        gv[2] = '{4'd7, 32'h0000_4000, 1'b1, 32, 0};
        gv[3] = '{4'd2, 32'h0000_0010, 1'b0, 1, 0};
        gv[4] = '{4'd0, 32'h0000_0013, 1'b0, 1, 2};
        gv[5] = '{4'd1, 32'h0000_0013, 1'b1, 1, 0};
        gv[6] = '{4'd3, 32'h0000_3FF8, 1'b0, 2, 0};
        gv[7] = '{4'd4, 32'h0000_3FF8, 1'b1, 4, 0};
        gv[8] = '{4'd5, 32'hFFFF_FFE0, 1'b1, 8, 2};

        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("reset_outs", {a_ready, d_valid, d_opcode, d_size, d_denied, d_data, d_corrupt}, '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_release_a_ready", {a_ready, d_valid}, 2'b10);

        for (int k = 0; k < 32; k++) begin
            pdata[k] = 32'hA500_0000 + k; pmask[k] = 4'hF; pcor[k] = 1'b0;
        end
        do_put(3'd0, 4'd7, 32'h0, 1'b0);
        for (int k = 0; k < 32; k++) pdata[k] = 32'hA500_0020 + k;
        do_put(3'd0, 4'd7, 32'h80, 1'b0);

        do_get(4'd7, 32'h80, 1'b0, 32, 0);
        chk("burst_last_word", last_data, 32'hA500_003F);
        do_get(4'd7, 32'h80, 1'b0, 32, 1);

        for (int k = 0; k < 4; k++) pdata[k] = 32'h1111_1111 * (k + 1);
        do_put(3'd0, 4'd4, 32'h10, 1'b0);
        do_get(4'd4, 32'h10, 1'b0, 4, 0);
        chk("putfull_last", last_data, 32'h4444_4444);

        pdata[0] = 32'hDEAD_BEEF; pmask[0] = 4'b0101;
        do_put(3'd1, 4'd2, 32'h10, 1'b0);
        do_get(4'd2, 32'h10, 1'b0, 1, 0);
        chk("putpartial_word", last_data, 32'h11AD_11EF);

        for (int k = 0; k < 4; k++) begin pdata[k] = $urandom; pmask[k] = 4'hF; end
        do_put(3'd2, 4'd4, 32'h20, 1'b1);
        do_get(4'd4, 32'h20, 1'b0, 4, 2);
        chk("unsupported_put_no_write", last_data, 32'hA500_000B);

        pdata[0] = 32'hCAFE_F00D; pdata[1] = 32'hBADC_0FFE; pcor[1] = 1'b1;
        do_put(3'd0, 4'd3, 32'h30, 1'b0);
        pcor[1] = 1'b0;
        do_get(4'd3, 32'h30, 1'b0, 2, 0);
        chk("corrupt_beat_no_write", last_data, 32'hA500_000D);

        pdata[0] = 32'h0BAD_0001; pdata[1] = 32'h0BAD_0002;
        do_put(3'd0, 4'd3, 32'h3FF8, 1'b0);
        do_put(3'd0, 4'd3, 32'h3FFC, 1'b1);

        for (int i = 0; i < 9; i++) do_get(gv[i].sz, gv[i].addr, gv[i].den, gv[i].n, gv[i].mode);

        for (int i = 0; i < 40; i++) begin
            int r;
            logic [3:0] sz;
            logic [31:0] ad;
            logic [2:0] op;
            r = $urandom_range(0, 9);
            sz = 4'($urandom_range(0, 7));
            ad = $urandom_range(0, 255);
            if ($urandom_range(0, 3) != 0) ad = ad & ~((32'h1 << sz) - 32'h1);
            if ($urandom_range(0, 9) == 0) ad = 32'h4000 + ($urandom_range(0, 15) << 4);
            if (r < 5) begin
                do_get(sz, ad, deny_f(3'd4, sz, ad), nb(sz), $urandom_range(0, 2));
            end else begin
                op = (r < 7) ? 3'd0 : (r < 9) ? 3'd1 : 3'd5;
                for (int k = 0; k < 32; k++) begin
                    pdata[k] = $urandom;
                    pmask[k] = (op == 3'd0) ? 4'hF : 4'($urandom);
                    pcor[k]  = ($urandom_range(0, 7) == 0);
                end
                do_put(op, sz, ad, deny_f(op, sz, ad));
            end
        end
        for (int k = 0; k < 32; k++) pcor[k] = 1'b0;

        a_valid = 1'b1; a_opcode = 3'd4; a_size = 4'd7; a_address = 32'h80; a_corrupt = 1'b0;
        t = 0;
        while (!a_ready && t < 100) begin @(negedge clk); t++; end
        @(negedge clk);
        a_valid = 1'b0; d_ready = 1'b1;
        got = 0; t = 0;
        while (got < 10 && t < 100) begin
            if (d_valid) got++;
            @(negedge clk);
            t++;
        end
        if (got < 10) expired("reset_burst_beats");
        #1 rst_n = 1'b0;
        #1 chk("midburst_reset", {d_valid, a_ready}, 2'b00);
        d_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_hold_quiet", {d_valid, a_ready}, 2'b00);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", {d_valid, a_ready}, 2'b01);
        do_get(4'd7, 32'h80, 1'b0, 32, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
